// File: rtl/d_cache_param_pkg.sv
// d_cache_param_pkg: shared types and constants for the far-memory controller
package d_cache_param_pkg;
   localparam int FM_Q_DEPTH_DEFAULT = 4;
   localparam int MEM_BEATS_IN_CL = 4;
   localparam logic [1:0] LAST_BEAT = 2'(MEM_BEATS_IN_CL - 1);
   typedef logic [19:0] t_address;
   typedef logic [31:0] t_word;
   typedef logic [32*MEM_BEATS_IN_CL-1:0] t_cl;
   typedef enum logic [1:0] {NO_FM_REQ, FILL_REQ_OP, DIRTY_EVICT_OP} t_fm_opcode;
   typedef enum logic [2:0] {S_IDLE, S_EVICT, S_FILL_REQ, S_FILL_WAIT, S_FILL_RSP} t_fm_ctrl_state;
   typedef struct packed {
      logic       valid;
      t_fm_opcode opcode;
      t_address   address;
      t_cl        cl;
   } t_fm_req;
   typedef struct packed {
      logic     valid;
      t_address address;
      t_cl      data;
   } t_fm_rd_rsp;
   typedef struct packed {
      t_fm_opcode  opcode;
      logic [15:0] line;
      t_cl         cl;
   } t_fm_entry;
endpackage

// File: rtl/d_cache_fm_fifo.sv
// d_cache_fm_fifo: request queue with wrap-around pointers; storage is never reset
module d_cache_fm_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wr_q, rd_q;
   // extra pointer bit tells full from empty when the indices coincide
   assign full_o = (wr_q - rd_q) == (AW+1)'(DEPTH);
   assign empty_o = wr_q == rd_q;
   assign data_o = mem_q[rd_q[AW-1:0]];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && !full_o) wr_q <= wr_q + 1'b1;
         if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   always_ff @(posedge clk)
      if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/d_cache_fm_ctrl.sv
// d_cache_fm_ctrl: serialises cache fills/evicts into 4-beat memory transfers
// D_CACHE_FM_CNT_EN adds saturating fill_cnt/evict_cnt outputs
module d_cache_fm_ctrl
   import d_cache_param_pkg::*;
#(
   parameter int FM_Q_DEPTH = FM_Q_DEPTH_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  t_fm_req    fm_req,
   output logic       fm_req_ready,
   output t_fm_rd_rsp fm_rd_rsp,
   output logic       mem_req_valid,
   input  logic       mem_req_ready,
   output logic       mem_req_wr,
   output t_address   mem_req_address,
   output t_word      mem_req_data,
   input  logic       mem_rsp_valid,
   input  t_word      mem_rsp_data
`ifdef D_CACHE_FM_CNT_EN
   ,
   output logic [15:0] fill_cnt,
   output logic [15:0] evict_cnt
`endif
);
   t_fm_ctrl_state state_q, state_d;
   logic [1:0] beat_q, rsp_cnt_q;
   logic rsp_err_q;
   logic [15:0] line_q;
   t_cl wcl_q, cl_q;
   t_fm_entry fifo_in, fifo_out;
   logic full, empty, push, pop, beat_fire, rsp_take, unused_bits;
   assign fifo_in = '{opcode: fm_req.opcode, line: fm_req.address[19:4], cl: fm_req.cl};
   assign unused_bits = ^fm_req.address[3:0];
   assign fm_req_ready = !full;
   assign push = fm_req.valid && !full && fm_req.opcode != NO_FM_REQ;
   d_cache_fm_fifo #(.DEPTH(FM_Q_DEPTH), .WIDTH($bits(t_fm_entry))) u_fifo (
      .clk(clk), .rst(rst), .push_i(push), .data_i(fifo_in), .pop_i(pop),
      .data_o(fifo_out), .full_o(full), .empty_o(empty)
   );
   assign mem_req_valid = state_q == S_EVICT || state_q == S_FILL_REQ;
   assign mem_req_wr = state_q == S_EVICT;
   assign mem_req_address = {line_q, beat_q, 2'b00};
   assign mem_req_data = wcl_q[32*beat_q +: 32];
   assign beat_fire = mem_req_valid && mem_req_ready;
   // responses may overtake the last read beat, so capture during S_FILL_REQ too
   assign rsp_take = mem_rsp_valid && (state_q == S_FILL_REQ || state_q == S_FILL_WAIT);
   assign fm_rd_rsp = (state_q == S_FILL_RSP) ? t_fm_rd_rsp'({1'b1, line_q, 4'h0, cl_q}) : '0;
   always_comb begin
      state_d = state_q;
      pop = 1'b0;
      case (state_q)
         S_IDLE: if (!empty) begin
            pop = 1'b1;
            state_d = (fifo_out.opcode == DIRTY_EVICT_OP) ? S_EVICT : S_FILL_REQ;
         end
         S_EVICT: state_d = (beat_fire && beat_q == LAST_BEAT) ? S_IDLE : S_EVICT;
         S_FILL_REQ: state_d = (beat_fire && beat_q == LAST_BEAT) ? S_FILL_WAIT : S_FILL_REQ;
         S_FILL_WAIT: state_d = (rsp_take && rsp_cnt_q == LAST_BEAT) ? S_FILL_RSP : S_FILL_WAIT;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         beat_q <= '0;
         rsp_cnt_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q <= beat_fire ? beat_q + 1'b1 : beat_q;
         rsp_cnt_q <= rsp_take ? rsp_cnt_q + 1'b1 : rsp_cnt_q;
         rsp_err_q <= rsp_err_q | (mem_rsp_valid && (state_q == S_IDLE || state_q == S_EVICT));
      end
   always_ff @(posedge clk) begin
      if (pop) begin
         line_q <= fifo_out.line;
         wcl_q <= fifo_out.cl;
      end
      if (rsp_take) cl_q[32*rsp_cnt_q +: 32] <= mem_rsp_data;
   end
`ifdef D_CACHE_FM_CNT_EN
   logic [15:0] fill_cnt_q, evict_cnt_q;
   logic evict_done;
   assign evict_done = state_q == S_EVICT && beat_fire && beat_q == LAST_BEAT;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fill_cnt_q <= '0;
         evict_cnt_q <= '0;
      end else begin
         if (state_q == S_FILL_RSP && fill_cnt_q != 16'hFFFF) fill_cnt_q <= fill_cnt_q + 1'b1;
         if (evict_done && evict_cnt_q != 16'hFFFF) evict_cnt_q <= evict_cnt_q + 1'b1;
      end
   assign fill_cnt = fill_cnt_q;
   assign evict_cnt = evict_cnt_q;
`endif
endmodule

// File: tb/tb_d_cache_fm_ctrl.sv
// tb_d_cache_fm_ctrl: directed stimulus against a transaction-level model of d_cache_fm_ctrl
module tb_d_cache_fm_ctrl;
   import d_cache_param_pkg::*;
   logic clk = 0, rst = 0;
   t_fm_req fm_req = '0;
   logic fm_req_ready, mem_req_valid, mem_req_wr;
   logic mem_req_ready = 1;
   t_fm_rd_rsp fm_rd_rsp;
   t_address mem_req_address;
   t_word mem_req_data, mem_rd = '0;
   logic mem_rv = 0, spur = 0, mem_rsp_valid;
   assign mem_rsp_valid = mem_rv | spur;
`ifdef D_CACHE_FM_CNT_EN
   logic [15:0] fill_cnt, evict_cnt;
`endif

   d_cache_fm_ctrl #(.FM_Q_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .fm_req(fm_req), .fm_req_ready(fm_req_ready),
      .fm_rd_rsp(fm_rd_rsp), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wr(mem_req_wr), .mem_req_address(mem_req_address), .mem_req_data(mem_req_data),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rd)
`ifdef D_CACHE_FM_CNT_EN
      , .fill_cnt(fill_cnt), .evict_cnt(evict_cnt)
`endif
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;
   task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct packed {logic wr; t_address a; t_word d;} t_beat;
   typedef struct packed {t_address a; t_cl d;} t_rsp;
   t_beat exp_beats[$], log_beats[$];
   t_rsp exp_rsp[$];
   t_word rd_pend[$];
   t_beat cur, prev_b, eb;
   t_rsp er, last_rsp;
   logic stall_q = 0;
   int fills_done = 0, evicts_done = 0, rsp_seen = 0, rsp_cyc = 0, push_cyc = 0;

   function automatic t_word mem_val(t_address a);
      return (a[19:4] == 16'h1234) ? 32'hA + 32'(a[3:2]) : {12'hC0D, a};
   endfunction

   // a request expands into four ascending word beats; a fill also yields one response
   task automatic model_add(t_fm_opcode op, t_address a, t_cl cl);
      t_cl fill;
      t_address wa;
      fill = '0;
      if (op == NO_FM_REQ) return;
      for (int k = 0; k < 4; k++) begin
         wa = {a[19:4], 4'h0} + t_address'(4 * k);
         exp_beats.push_back('{op == DIRTY_EVICT_OP, wa, (op == DIRTY_EVICT_OP) ? cl[32*k +: 32] : 32'h0});
         fill[32*k +: 32] = mem_val(wa);
      end
      if (op == FILL_REQ_OP) exp_rsp.push_back('{{a[19:4], 4'h0}, fill});
   endtask

   always @(negedge clk) begin
      cur = '{mem_req_wr, mem_req_address, mem_req_data};
      if (!rst) begin
         if (stall_q) chk("hold", {mem_req_valid, cur}, {1'b1, prev_b});
         if (mem_req_valid && mem_req_ready) begin
            log_beats.push_back(cur);
            if (!cur.wr) rd_pend.push_back(mem_val(cur.a));
            if (exp_beats.size() == 0) chk("beat_unexpected", {1'b1, cur}, '0);
            else begin
               eb = exp_beats.pop_front();
               if (eb.wr) chk("wr_beat", cur, eb);
               else chk("rd_beat", {cur.wr, cur.a}, {eb.wr, eb.a});
               if (eb.wr && eb.a[3:2] == 2'd3) evicts_done++;
            end
         end
         if (fm_rd_rsp.valid) begin
            rsp_seen++;
            rsp_cyc = cyc;
            last_rsp = '{fm_rd_rsp.address, fm_rd_rsp.data};
            if (exp_rsp.size() == 0) chk("rsp_unexpected", {1'b1, last_rsp}, '0);
            else begin
               er = exp_rsp.pop_front();
               chk("fill_rsp", last_rsp, er);
               fills_done++;
            end
         end
      end
      stall_q = !rst && mem_req_valid && !mem_req_ready;
      prev_b = cur;
   end

   // one-cycle memory: each accepted read returns its word in the following cycle
   always @(posedge clk) begin
      #1;
      if (rd_pend.size() > 0) begin
         mem_rv = 1;
         mem_rd = rd_pend.pop_front();
      end else mem_rv = 0;
   end

   task automatic push(t_fm_opcode op, t_address a, t_cl cl);
      int n = 0;
      fm_req = '{1'b1, op, a, cl};
      while (!fm_req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("push_ready", fm_req_ready, 1'b1);
      push_cyc = cyc;
      if (fm_req_ready) model_add(op, a, cl);
      @(posedge clk); #1;
      fm_req.valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_beats.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", {exp_beats.size() == 0, exp_rsp.size() == 0}, 2'b11);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1;
      mem_rv = 0;
      rd_pend.delete();
      exp_beats.delete();
      exp_rsp.delete();
      fills_done = 0;
      evicts_done = 0;
      #1;
      chk("rst_valid", mem_req_valid, 1'b0);
      chk("rst_rsp", fm_rd_rsp, '0);
      chk("rst_ready", fm_req_ready, 1'b1);
      chk("rst_err", dut.rsp_err_q, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   t_cl cl_a = 128'h44444444_33333333_22222222_11111111;
   t_cl cl_b = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
   int n, r0;
   initial begin
      #1 rst = 1;
      #2;
      chk("init_valid", mem_req_valid, 1'b0);
      chk("init_ready", fm_req_ready, 1'b1);
      chk("init_rsp", fm_rd_rsp, '0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      // single fill
      log_beats.delete();
      push(FILL_REQ_OP, 20'h12340, cl_b);
      wait_idle();
      chk("fill_latency", rsp_cyc - push_cyc, 7);
      chk("fill_lit", last_rsp, {20'h12340, 128'h0000000D_0000000C_0000000B_0000000A});
      chk("fill_addrs", {log_beats[0].a, log_beats[1].a, log_beats[2].a, log_beats[3].a},
          80'h12340_12344_12348_1234C);
      // dirty evict
      log_beats.delete();
      r0 = rsp_seen;
      push(DIRTY_EVICT_OP, 20'h00FF0, cl_a);
      wait_idle();
      chk("evict_lit", {log_beats[0], log_beats[3]}, {1'b1, 20'h00FF0, 32'h11111111, 1'b1, 20'h00FFC, 32'h44444444});
      chk("evict_no_rsp", rsp_seen - r0, 0);
      // NO_FM_REQ is dropped
      log_beats.delete();
      push(NO_FM_REQ, 20'h55550, cl_a);
      repeat (10) @(posedge clk);
      #1;
      chk("noop_dropped", log_beats.size(), 0);
      // backpressure 1-0-0-1 on an evict and on a fill
      for (int j = 0; j < 2; j++) begin
         log_beats.delete();
         mem_req_ready = 0;
         push(j == 0 ? DIRTY_EVICT_OP : FILL_REQ_OP, 20'h0ABC0, cl_b);
         n = 0;
         while (!mem_req_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         for (int i = 0; i < 12; i++) begin
            mem_req_ready = (i % 4 == 0) || (i % 4 == 3);
            @(posedge clk); #1;
         end
         mem_req_ready = 1;
         wait_idle();
         chk("bp_beat_count", log_beats.size(), 4);
      end
      // full queue: A occupies the FSM, B..E fill the queue, F is held off
      mem_req_ready = 0;
      push(FILL_REQ_OP, 20'h10000, cl_a);
      repeat (3) @(posedge clk);
      #1;
      push(DIRTY_EVICT_OP, 20'h20010, cl_a);
      push(FILL_REQ_OP, 20'h12340, cl_b);
      push(FILL_REQ_OP, 20'h30020, cl_a);
      push(DIRTY_EVICT_OP, 20'h40030, cl_b);
      chk("full_ready", fm_req_ready, 1'b0);
      fm_req = '{1'b1, FILL_REQ_OP, 20'h50040, cl_a};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("held_off", fm_req_ready, 1'b0);
      end
      mem_req_ready = 1;
      push(FILL_REQ_OP, 20'h50040, cl_a);
      wait_idle();
      chk("err_clean", dut.rsp_err_q, 1'b0);
      // reset in the middle of a fill
      log_beats.delete();
      push(FILL_REQ_OP, 20'h22220, cl_a);
      n = 0;
      while (log_beats.size() < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      do_reset();
      push(FILL_REQ_OP, 20'h12340, cl_a);
      wait_idle();
      chk("post_rst_fill", last_rsp, {20'h12340, 128'h0000000D_0000000C_0000000B_0000000A});
      // spurious response while idle
      spur = 1;
      @(posedge clk); #1;
      spur = 0;
      chk("spurious_err", dut.rsp_err_q, 1'b1);
      do_reset();
`ifdef D_CACHE_FM_CNT_EN
      chk("cnt_rst", {fill_cnt, evict_cnt}, 32'h0);
      push(FILL_REQ_OP, 20'h12340, cl_a);
      push(DIRTY_EVICT_OP, 20'h00FF0, cl_a);
      push(FILL_REQ_OP, 20'h60000, cl_b);
      push(DIRTY_EVICT_OP, 20'h70010, cl_b);
      push(FILL_REQ_OP, 20'h80020, cl_a);
      wait_idle();
      chk("cnt_lit", {fill_cnt, evict_cnt}, {16'd3, 16'd2});
      chk("cnt_model", {fill_cnt, evict_cnt}, {16'(fills_done), 16'(evicts_done)});
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
